// File: rtl/demux_pkg.sv
// Shared types and constants for the demux_stream block: channel slot
// state encoding, default geometry and the drop counter width.
package demux_pkg;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 8;
    localparam int DROP_CNT_W   = 8;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot for a single demux output channel with a
// valid/ready drain side; a write while draining replaces the word.
//
// state    | meaning
// ---------+-------------------------------------------
// CH_EMPTY | no word held, out valid low
// CH_FULL  | word held in data, waiting for rd_ready
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             writable
);

    ch_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CH_EMPTY: if (wr) state_d = CH_FULL;
            CH_FULL: begin
                if (wr)            state_d = CH_FULL;
                else if (rd_ready) state_d = CH_EMPTY;
            end
            default: state_d = CH_EMPTY;
        endcase
    end

    // Data is only ever replaced by a write, never cleared outside reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (wr) begin
            data <= wr_data;
        end
    end

    assign valid    = (state_q == CH_FULL);
    assign writable = (state_q == CH_EMPTY) || rd_ready;

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-N stream demultiplexer with per-channel holding slots.
// Optional broadcast input enabled by defining DEMUX_STREAM_BCAST_EN.
module demux_stream
    import demux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
`ifdef DEMUX_STREAM_BCAST_EN
    input  logic                      in_bcast,
`endif
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [DROP_CNT_W-1:0]     drop_cnt
);

    logic [CHANNELS-1:0] writable;
    logic [CHANNELS-1:0] wr;
    logic [31:0]         sel_ext;
    logic                sel_legal;
    logic                sel_writable;
    logic                bcast;
    logic                xfer;
    logic                drop;

`ifdef DEMUX_STREAM_BCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    assign sel_ext   = 32'(in_sel);
    assign sel_legal = (sel_ext < 32'(CHANNELS));

    // Loop-compare rather than writable[in_sel] so a non-power-of-2
    // CHANNELS never indexes past the vector.
    always_comb begin
        sel_writable = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_ext == 32'(i)) sel_writable = writable[i];
        end
    end

    assign in_ready = en && (bcast ? (&writable) : (!sel_legal || sel_writable));
    assign xfer     = in_valid && in_ready;
    assign drop     = xfer && !bcast && !sel_legal;

    always_comb begin
        wr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr[i] = xfer && (bcast || (sel_ext == 32'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr       (wr[i]),
            .wr_data  (in_data),
            .rd_ready (out_ready[i]),
            .valid    (out_valid[i]),
            .data     (out_data[i*WIDTH +: WIDTH]),
            .writable (writable[i])
        );
    end

endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream: an 8-channel instance checked every
// cycle against a reference model, plus a 6-channel instance for drops.
module tb_demux_stream;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        en, in_valid, in_ready, bcast_tb;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic [7:0]  out_valid, out_ready, drop_cnt;
    logic [63:0] out_data;

    logic        en6, in_valid6, in_ready6;
    logic [7:0]  in_data6;
    logic [2:0]  in_sel6;
    logic [5:0]  out_valid6, out_ready6;
    logic [47:0] out_data6;
    logic [7:0]  drop_cnt6;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demux_stream #(.WIDTH(8), .CHANNELS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel),
`ifdef DEMUX_STREAM_BCAST_EN
        .in_bcast(bcast_tb),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .drop_cnt(drop_cnt)
    );

    demux_stream #(.WIDTH(8), .CHANNELS(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en6), .in_valid(in_valid6), .in_ready(in_ready6),
        .in_data(in_data6), .in_sel(in_sel6),
`ifdef DEMUX_STREAM_BCAST_EN
        .in_bcast(1'b0),
`endif
        .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6), .drop_cnt(drop_cnt6)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: per-channel expected words, fullness and drop count.
    logic [7:0] sb [8][$];
    logic [7:0] full_m, wr_m;
    logic       exp_ready;
    int         drop_m;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) sb[i].delete();
            full_m = '0;
            drop_m = 0;
        end else begin
            if (bcast_tb) exp_ready = en && ((~full_m | out_ready) == 8'hFF);
            else          exp_ready = en && (!full_m[in_sel] || out_ready[in_sel]);
            check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
            check_eq("out_valid", 64'(out_valid), 64'(full_m));
            check_eq("drop_cnt", 64'(drop_cnt), 64'(drop_m));
            for (int i = 0; i < 8; i++) begin
                if (full_m[i] && out_ready[i]) begin
                    check_eq("sb_depth", 64'(sb[i].size()), 64'd1);
                    if (sb[i].size() > 0) check_eq("out_data", 64'(out_data[i*8 +: 8]), 64'(sb[i].pop_front()));
                end
            end
            wr_m = '0;
            if (in_valid && exp_ready) begin
                if (bcast_tb) wr_m = 8'hFF;
                else          wr_m[in_sel] = 1'b1;
            end
            for (int i = 0; i < 8; i++) if (wr_m[i]) sb[i].push_back(in_data);
            full_m = (full_m & ~out_ready) | wr_m;
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0;
        out_ready = '0; bcast_tb = 1'b0;
        en6 = 1'b1; in_valid6 = 1'b0; in_data6 = '0; in_sel6 = '0; out_ready6 = '0;
        step(); step();
        rst_n = 1'b1;

        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'h00);
        check_eq("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_data", out_data, 64'd0);
        step();

        // Fill all eight slots, then a blocked ninth write to channel 3.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_sel = 3'(i); in_data = 8'hA0 + 8'(i);
            step();
        end
        in_sel = 3'd3; in_data = 8'h33;
        @(negedge clk);
        check_eq("fill_valid", 64'(out_valid), 64'hFF);
        check_eq("ninth_stall", 64'(in_ready), 64'd0);
        step();
        out_ready = 8'h08;
        @(negedge clk);
        check_eq("ninth_ready", 64'(in_ready), 64'd1);
        check_eq("drain_ch3", 64'(out_data[24 +: 8]), 64'hA3);
        step();
        in_valid = 1'b0; out_ready = '0;
        @(negedge clk);
        check_eq("replace_ch3", 64'(out_data[24 +: 8]), 64'h33);
        check_eq("replace_valid", 64'(out_valid), 64'hFF);
        out_ready = 8'hFF;
        step(); step();
        out_ready = '0;

        // Full-rate stream to channel 5.
        out_ready = 8'h20;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_sel = 3'd5; in_data = 8'($urandom);
            @(negedge clk);
            check_eq("stream_ready", 64'(in_ready), 64'd1);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("stream_last_valid", 64'(out_valid[5]), 64'd1);
        step();
        out_ready = '0;

        // Enable low: writes blocked, full slot still drains.
        in_valid = 1'b1; in_sel = 3'd2; in_data = 8'h77;
        step();
        en = 1'b0; in_sel = 3'd0; in_data = 8'h10;
        @(negedge clk);
        check_eq("en0_ready", 64'(in_ready), 64'd0);
        step(); step();
        out_ready = 8'h04;
        @(negedge clk);
        check_eq("en0_ch2_held", 64'(out_valid), 64'h04);
        check_eq("en0_ch2_data", 64'(out_data[16 +: 8]), 64'h77);
        step();
        @(negedge clk);
        check_eq("en0_drained", 64'(out_valid), 64'h00);
        step();
        in_valid = 1'b0; en = 1'b1; out_ready = '0;

        // Six-channel instance: illegal select 7, drop counter saturation.
        in_valid6 = 1'b1; in_sel6 = 3'd1; in_data6 = 8'h66;
        step();
        in_sel6 = 3'd7;
        for (int i = 0; i < 300; i++) begin
            in_data6 = 8'(i);
            @(negedge clk);
            check_eq("drop_ready", 64'(in_ready6), 64'd1);
            if (i == 255) check_eq("drop_cnt_255", 64'(drop_cnt6), 64'd255);
            step();
        end
        in_valid6 = 1'b0;
        @(negedge clk);
        check_eq("drop_valid", 64'(out_valid6), 64'h02);
        check_eq("drop_data", 64'(out_data6[8 +: 8]), 64'h66);
        check_eq("drop_sat", 64'(drop_cnt6), 64'd255);
        step();

`ifdef DEMUX_STREAM_BCAST_EN
        // Broadcast stalls on a full, non-draining channel 0.
        in_valid = 1'b1; in_sel = 3'd0; in_data = 8'h11;
        step();
        bcast_tb = 1'b1; in_sel = 3'd3; in_data = 8'h5A;
        @(negedge clk);
        check_eq("bcast_stall", 64'(in_ready), 64'd0);
        step();
        out_ready = 8'h01;
        @(negedge clk);
        check_eq("bcast_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0; bcast_tb = 1'b0; out_ready = '0;
        @(negedge clk);
        check_eq("bcast_valid", 64'(out_valid), 64'hFF);
        check_eq("bcast_data", out_data, {8{8'h5A}});
        out_ready = 8'hFF;
        step(); step();
        out_ready = '0;
`endif

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = 3'(i); in_data = 8'hC0 + 8'(i);
            step();
        end
        #2;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check_eq("async_rst_valid", 64'(out_valid), 64'h00);
        check_eq("async_rst_data", out_data, 64'd0);
        check_eq("async_rst_drop6", 64'(drop_cnt6), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_valid", 64'(out_valid), 64'h00);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
